axi_lite_from_mem: RTL

- Converts a simple request/grant memory interface into an AXI4-Lite master port. Used by cores, debug modules and DMA descriptors that need to reach the full AXI crossbar.
- Sits directly upstream of the AXI-Lite-to-AXI4 adapter and drives that adapter's slave port.
- Supports one outstanding transaction at a time. AW and W are issued independently. Responses return in order on a one-cycle response pulse.

---
 rtl/axi_lite_from_mem_pkg.sv | 37 +++
 rtl/axi_lite_from_mem.sv | 126 ++++++++++++
 2 files changed

// File: rtl/axi_lite_from_mem_pkg.sv
// axi_lite_from_mem_pkg: default AXI4-Lite request/response structs (32-bit address and data)
package axi_lite_from_mem_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ax_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_t;
    typedef struct packed {
        logic [1:0] resp;
    } b_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_t;
    typedef struct packed {
        ax_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ax_t  ar;
        logic ar_valid;
        logic r_ready;
    } req_t;
    typedef struct packed {
        logic aw_ready;
        logic w_ready;
        b_t   b;
        logic b_valid;
        logic ar_ready;
        r_t   r;
        logic r_valid;
    } resp_t;
endpackage

// File: rtl/axi_lite_from_mem.sv
// axi_lite_from_mem: request/grant memory port to AXI4-Lite master, one outstanding transaction
module axi_lite_from_mem #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter type req_lite_t = axi_lite_from_mem_pkg::req_t,
    parameter type resp_lite_t = axi_lite_from_mem_pkg::resp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mem_req_i,
    output logic                   mem_gnt_o,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic                   mem_we_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    input  logic [DataWidth/8-1:0] mem_be_i,
    input  logic [2:0]             mem_prot_i,
    output logic                   mem_rsp_valid_o,
    output logic [DataWidth-1:0]   mem_rsp_rdata_o,
    output logic                   mem_rsp_err_o,
    output req_lite_t              axi_req_o,
    input  resp_lite_t             axi_rsp_i,
    output logic                   busy_o
);
    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R} state_t;
    state_t                 state;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   wdata_q, rdata_q;
    logic [DataWidth/8-1:0] be_q;
    logic [2:0]             prot_q;
    logic                   aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q, rsp_valid_q, err_q;
    logic                   aw_left, w_left;
    logic                   unused_resp_lsb;
    assign mem_gnt_o       = mem_req_i && state == IDLE;
    assign aw_left         = aw_valid_q && !axi_rsp_i.aw_ready;
    assign w_left          = w_valid_q && !axi_rsp_i.w_ready;
    assign busy_o          = state != IDLE;
    assign mem_rsp_valid_o = rsp_valid_q;
    assign mem_rsp_rdata_o = rdata_q;
    assign mem_rsp_err_o   = err_q;
    assign unused_resp_lsb = axi_rsp_i.b.resp[0] ^ axi_rsp_i.r.resp[0];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            prot_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: if (mem_req_i) begin
                    addr_q     <= mem_addr_i;
                    wdata_q    <= mem_wdata_i;
                    be_q       <= mem_be_i;
                    prot_q     <= mem_prot_i;
                    aw_valid_q <= mem_we_i;
                    w_valid_q  <= mem_we_i;
                    ar_valid_q <= !mem_we_i;
                    state      <= mem_we_i ? WRITE : READ;
                end
                // AW and W retire independently; B wait starts once neither is left
                WRITE: begin
                    aw_valid_q <= aw_left;
                    w_valid_q  <= w_left;
                    if (!aw_left && !w_left) begin
                        state     <= WAIT_B;
                        b_ready_q <= 1'b1;
                    end
                end
                WAIT_B: if (axi_rsp_i.b_valid) begin
                    state       <= IDLE;
                    b_ready_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rdata_q     <= '0;
                    err_q       <= axi_rsp_i.b.resp[1];
                end
                READ: if (axi_rsp_i.ar_ready) begin
                    state      <= WAIT_R;
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b1;
                end
                WAIT_R: if (axi_rsp_i.r_valid) begin
                    state       <= IDLE;
                    r_ready_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rdata_q     <= DataWidth'(axi_rsp_i.r.data);
                    err_q       <= axi_rsp_i.r.resp[1];
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.prot  = prot_q;
        axi_req_o.aw_valid = aw_valid_q;
        axi_req_o.w.data   = wdata_q;
        axi_req_o.w.strb   = be_q;
        axi_req_o.w_valid  = w_valid_q;
        axi_req_o.b_ready  = b_ready_q;
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.prot  = prot_q;
        axi_req_o.ar_valid = ar_valid_q;
        axi_req_o.r_ready  = r_ready_q;
    end
`ifndef SYNTHESIS
    if (DataWidth != 32 && DataWidth != 64) begin : g_bad_width
        $fatal(1, "axi_lite_from_mem: DataWidth must be 32 or 64");
    end
    aw_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        axi_req_o.aw_valid && !axi_rsp_i.aw_ready |=> axi_req_o.aw_valid && $stable(axi_req_o.aw));
    w_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        axi_req_o.w_valid && !axi_rsp_i.w_ready |=> axi_req_o.w_valid && $stable(axi_req_o.w));
    ar_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        axi_req_o.ar_valid && !axi_rsp_i.ar_ready |=> axi_req_o.ar_valid && $stable(axi_req_o.ar));
`endif
endmodule
